// File: rtl/issue_ctrl.sv
// issue_ctrl: in-order issue controller between decode and execute.
// Holds decoded instructions until operands/destination are free (32-entry
// scoreboard), parks issue behind control instructions until execute
// resolves them, and pulses flush on a taken branch/jump.
// Optional feature macro: ISSUE_CTRL_FORWARD_EN enables forwarding from the
// instruction issued in the previous cycle (non-load producers only).
module issue_ctrl #(
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [AW-1:0]   dec_rd,
  input  logic [AW-1:0]   dec_rs1,
  input  logic [AW-1:0]   dec_rs2,
  input  logic            dec_use_rs1,
  input  logic            dec_use_rs2,
  input  logic            dec_wr_rd,
  input  logic            dec_is_load,
  input  logic            dec_is_ctrl,
  output logic            ex_valid,
  input  logic            ex_resolve,
  input  logic            ex_taken,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  output logic            flush,
  output logic [NREG-1:0] busy,
  output logic            fwd_rs1,
  output logic            fwd_rs2
);

`ifdef ISSUE_CTRL_FORWARD_EN
  localparam logic FWD_EN = 1'b1;
`else
  localparam logic FWD_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            ex_valid_q, ex_valid_d;
  logic            flush_q, flush_d;
  logic            fwd_rs1_q, fwd_rs1_d;
  logic            fwd_rs2_q, fwd_rs2_d;
  // Last issued producer, used only to qualify forwarding.
  logic [AW-1:0]   ex_rd_q, ex_rd_d;
  logic            ex_wr_q, ex_wr_d;
  logic            ex_ld_q, ex_ld_d;

  logic raw1_s, raw2_s, waw_s;
  logic fwd_src_ok_s, fwd_hit1_s, fwd_hit2_s;
  logic hazard_s, ready_s, fire_s;

  // Hazard detection on the registered scoreboard; writeback does not bypass.
  always_comb begin
    raw1_s       = dec_use_rs1 & busy_q[dec_rs1];
    raw2_s       = dec_use_rs2 & busy_q[dec_rs2];
    waw_s        = dec_wr_rd & busy_q[dec_rd];
    // A producer is forwardable only in the cycle right after it issued and
    // only when its result is not a late-arriving load value.
    fwd_src_ok_s = FWD_EN & ex_valid_q & ex_wr_q & ~ex_ld_q;
    fwd_hit1_s   = fwd_src_ok_s & raw1_s & (dec_rs1 == ex_rd_q);
    fwd_hit2_s   = fwd_src_ok_s & raw2_s & (dec_rs2 == ex_rd_q);
    hazard_s     = (raw1_s & ~fwd_hit1_s) | (raw2_s & ~fwd_hit2_s) | waw_s;
    ready_s      = (state_q == ST_RUN) & ~hazard_s;
    fire_s       = dec_valid & ready_s;
  end

  assign dec_ready = ready_s;

  // Control FSM next-state: park in WAIT behind a control instruction.
  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (fire_s && dec_is_ctrl) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_WAIT: begin
        if (ex_resolve) begin
          if (ex_taken) begin
            flush_d = 1'b1;
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Scoreboard update: set on issue, clear on writeback, x0 never busy.
  always_comb begin
    busy_d = busy_q;
    if (fire_s && dec_wr_rd && (dec_rd != {AW{1'b0}})) begin
      busy_d[dec_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    if (wb_valid && (wb_rd != {AW{1'b0}})) begin
      busy_d[wb_rd] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Issue pulse, forwarding flags and producer tracking.
  always_comb begin
    ex_valid_d = fire_s;
    fwd_rs1_d  = fire_s & fwd_hit1_s;
    fwd_rs2_d  = fire_s & fwd_hit2_s;
    if (fire_s) begin
      ex_rd_d = dec_rd;
      ex_wr_d = dec_wr_rd & (dec_rd != {AW{1'b0}});
      ex_ld_d = dec_is_load;
    end else begin
      ex_rd_d = ex_rd_q;
      ex_wr_d = ex_wr_q;
      ex_ld_d = ex_ld_q;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      busy_q     <= {NREG{1'b0}};
      ex_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      fwd_rs1_q  <= 1'b0;
      fwd_rs2_q  <= 1'b0;
      ex_rd_q    <= {AW{1'b0}};
      ex_wr_q    <= 1'b0;
      ex_ld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      ex_valid_q <= ex_valid_d;
      flush_q    <= flush_d;
      fwd_rs1_q  <= fwd_rs1_d;
      fwd_rs2_q  <= fwd_rs2_d;
      ex_rd_q    <= ex_rd_d;
      ex_wr_q    <= ex_wr_d;
      ex_ld_q    <= ex_ld_d;
    end
  end

  assign ex_valid = ex_valid_q;
  assign flush    = flush_q;
  assign busy     = busy_q;
  assign fwd_rs1  = fwd_rs1_q;
  assign fwd_rs2  = fwd_rs2_q;

endmodule
